// File: rtl/harmony_beat_sequencer_if.sv
// ---------------------------------------------------------------------------
// harmony_beat_sequencer_if
// Control/status bundle between the beat sequencer and its user.
//   play      : level, 1 = run, 0 = pause
//   restart   : one-cycle pulse, rewind to beat 0
//   loop_en   : 1 = wrap after the last beat
//   tempo_sel : 00 nominal, 01 half, 10 double, 11 quadruple speed
//   beats     : beat index to the players, 8'hFF = silence
//   beat_tick : one-cycle pulse with each new beat index
//   playing   : sequencer is in PLAY
//   done      : sequencer is in DONE
// master drives the controls, slave (the sequencer) drives the status.
// ---------------------------------------------------------------------------
interface harmony_beat_sequencer_if;
    logic       play;
    logic       restart;
    logic       loop_en;
    logic [1:0] tempo_sel;
    logic [7:0] beats;
    logic       beat_tick;
    logic       playing;
    logic       done;

    modport master (
        output play, restart, loop_en, tempo_sel,
        input  beats, beat_tick, playing, done
    );

    modport slave (
        input  play, restart, loop_en, tempo_sel,
        output beats, beat_tick, playing, done
    );
endinterface

// File: rtl/harmony_beat_sequencer.sv
// ---------------------------------------------------------------------------
// harmony_beat_sequencer
// Divides CLOCK_50 into beat periods and steps the beat index 0..LAST_BEAT
// for the harmony/melody player lookup tables. Silence is signalled with the
// out-of-range index 8'hFF.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : harmony_beat_sequencer_if.slave (controls in, status out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | stopped, silent, waiting for play
// PLAY  | counting ticks, beats = idx
// PAUSE | idx/tick_cnt frozen, silent, waiting for play
// DONE  | song ended without loop, silent until play drops
// ---------------------------------------------------------------------------
module harmony_beat_sequencer #(
    parameter int unsigned TICKS_PER_BEAT = 6250000,
    parameter int unsigned LAST_BEAT      = 158
) (
    input  logic                      CLOCK_50,
    input  logic                      rst,
    harmony_beat_sequencer_if.slave   bus
);

    localparam logic [31:0] TPB      = 32'(TICKS_PER_BEAT);
    localparam logic [7:0]  LAST_IDX = 8'(LAST_BEAT);
    localparam logic [7:0]  SILENT   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic [31:0] period_q, period_d;
    logic [7:0]  beats_q, beats_d;
    logic        beat_tick_q, beat_tick_d;
    logic        playing_q, playing_d;
    logic        done_q, done_d;

    logic [31:0] period_sel;

    // Beat length requested by the current tempo; only sampled at beat start.
    always_comb begin
        period_sel = TPB;
        case (bus.tempo_sel)
            2'b00:   period_sel = TPB;
            2'b01:   period_sel = TPB << 1;
            2'b10:   period_sel = TPB >> 1;
            default: period_sel = TPB >> 2;
        endcase
        if (period_sel == 32'd0) begin
            period_sel = 32'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tick_cnt_d  = tick_cnt_q;
        period_d    = period_q;
        beat_tick_d = 1'b0;

        if (bus.restart) begin
            idx_d      = 8'd0;
            tick_cnt_d = 32'd0;
            period_d   = period_sel;
            if (bus.play) begin
                state_d     = PLAY;
                beat_tick_d = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.play) begin
                        state_d     = PLAY;
                        idx_d       = 8'd0;
                        tick_cnt_d  = 32'd0;
                        period_d    = period_sel;
                        beat_tick_d = 1'b1;
                    end
                end
                PLAY: begin
                    // Pause takes priority over a coincident beat boundary.
                    if (!bus.play) begin
                        state_d = PAUSE;
                    end else if (tick_cnt_q == period_q - 32'd1) begin
                        tick_cnt_d = 32'd0;
                        period_d   = period_sel;
                        if (idx_q < LAST_IDX) begin
                            idx_d       = idx_q + 8'd1;
                            beat_tick_d = 1'b1;
                        end else if (bus.loop_en) begin
                            idx_d       = 8'd0;
                            beat_tick_d = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 32'd1;
                    end
                end
                PAUSE: begin
                    if (bus.play) begin
                        state_d = PLAY;
                    end
                end
                DONE: begin
                    if (!bus.play) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs follow the next state so they are registered alongside it.
        beats_d   = (state_d == PLAY) ? idx_d : SILENT;
        playing_d = (state_d == PLAY);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 8'd0;
            tick_cnt_q  <= 32'd0;
            period_q    <= TPB;
            beats_q     <= SILENT;
            beat_tick_q <= 1'b0;
            playing_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tick_cnt_q  <= tick_cnt_d;
            period_q    <= period_d;
            beats_q     <= beats_d;
            beat_tick_q <= beat_tick_d;
            playing_q   <= playing_d;
            done_q      <= done_d;
        end
    end

    assign bus.beats     = beats_q;
    assign bus.beat_tick = beat_tick_q;
    assign bus.playing   = playing_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_harmony_beat_sequencer.sv
// ---------------------------------------------------------------------------
// tb_harmony_beat_sequencer
// Scoreboard bench: a song-level model predicts the outputs after each edge,
// pushes them into a queue, and a monitor compares them after every edge.
// ---------------------------------------------------------------------------
module tb_harmony_beat_sequencer;

    localparam int T    = 4;
    localparam int LAST = 158;

    logic clk;
    logic rst;

    harmony_beat_sequencer_if hb_if ();

    harmony_beat_sequencer #(
        .TICKS_PER_BEAT(T),
        .LAST_BEAT     (LAST)
    ) dut (
        .CLOCK_50(clk),
        .rst     (rst),
        .bus     (hb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int out_cyc = 0;

    // {beats, beat_tick, playing, done}
    logic [10:0] exp_q[$];

    // Song-level model: what the listener hears.
    string m_mode;     // "stopped", "running", "paused", "finished"
    int    m_pos;      // beat being played
    int    m_left;     // cycles of the current beat still to be played
    logic  m_tick;

    function automatic int beat_len(input logic [1:0] t);
        int len;
        case (t)
            2'd0:    len = T;
            2'd1:    len = T * 2;
            2'd2:    len = T / 2;
            default: len = T / 4;
        endcase
        if (len < 1) len = 1;
        return len;
    endfunction

    function automatic logic [10:0] model_out();
        logic [7:0] b;
        b = (m_mode == "running") ? 8'(m_pos) : 8'hFF;
        return {b, m_tick, logic'(m_mode == "running"), logic'(m_mode == "finished")};
    endfunction

    task automatic model_reset();
        m_mode = "stopped";
        m_pos  = 0;
        m_left = T;
        m_tick = 1'b0;
    endtask

    task automatic start_beat(input int pos, input logic [1:0] t);
        m_pos  = pos;
        m_left = beat_len(t);
        m_tick = 1'b1;
    endtask

    task automatic model_step(input logic p, input logic r, input logic l, input logic [1:0] t);
        m_tick = 1'b0;
        if (r) begin
            if (p) begin
                m_mode = "running";
                start_beat(0, t);
            end else begin
                m_mode = "stopped";
                m_pos  = 0;
            end
        end else if (m_mode == "stopped") begin
            if (p) begin
                m_mode = "running";
                start_beat(0, t);
            end
        end else if (m_mode == "running") begin
            if (!p) begin
                m_mode = "paused";
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_pos < LAST)  start_beat(m_pos + 1, t);
                    else if (l)        start_beat(0, t);
                    else               m_mode = "finished";
                end
            end
        end else if (m_mode == "paused") begin
            if (p) m_mode = "running";
        end else begin
            if (!p) m_mode = "stopped";
        end
    endtask

    // One clock of stimulus: drive at the falling edge, predict the next edge.
    task automatic cycle(input logic p, input logic r, input logic l,
                         input logic [1:0] t, input bit do_rst);
        @(negedge clk);
        hb_if.play      = p;
        hb_if.restart   = r;
        hb_if.loop_en   = l;
        hb_if.tempo_sel = t;
        if (do_rst) begin
            rst = 1'b1;
            #1;
            n_cmp++;
            if (hb_if.beats !== 8'hFF || hb_if.playing !== 1'b0 ||
                hb_if.beat_tick !== 1'b0 || hb_if.done !== 1'b0) begin
                n_bad++;
                $display("FAIL async_rst: got beats=%0d tick=%b playing=%b done=%b, expected beats=255 tick=0 playing=0 done=0",
                         hb_if.beats, hb_if.beat_tick, hb_if.playing, hb_if.done);
            end
            model_reset();
        end else begin
            rst = 1'b0;
            model_step(p, r, l, t);
        end
        exp_q.push_back(model_out());
    endtask

    // Monitor: outputs are presented every cycle, compare after each edge.
    initial begin
        logic [10:0] e;
        logic [10:0] g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {hb_if.beats, hb_if.beat_tick, hb_if.playing, hb_if.done};
                out_cyc++;
                n_cmp++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL outputs cyc%0d: got beats=%0d tick=%b playing=%b done=%b, expected beats=%0d tick=%b playing=%b done=%b",
                             out_cyc, g[10:3], g[2], g[1], g[0], e[10:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        logic       p, r, l;
        logic [1:0] t;
        bit         hit;

        rst             = 1'b1;
        hb_if.play      = 1'b0;
        hb_if.restart   = 1'b0;
        hb_if.loop_en   = 1'b0;
        hb_if.tempo_sel = 2'b00;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (hb_if.beats !== 8'hFF || hb_if.beat_tick !== 1'b0 ||
            hb_if.playing !== 1'b0 || hb_if.done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got beats=%0d tick=%b playing=%b done=%b, expected beats=255 tick=0 playing=0 done=0",
                     hb_if.beats, hb_if.beat_tick, hb_if.playing, hb_if.done);
        end

        // Whole song at nominal tempo, no loop; play stays high in DONE.
        repeat (700) cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        // Restart while DONE with play low -> silent IDLE.
        cycle(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // Looping song: wraps 158 -> 0.
        repeat (700) cycle(1'b1, 1'b0, 1'b1, 2'b00, 1'b0);

        // Restart mid-song, then asynchronous reset mid-beat at beat 77.
        cycle(1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            if (m_mode == "running" && m_pos == 77 && m_left == 2) hit = 1'b1;
            else cycle(1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL reach_beat77: got no beat 77 within 2000 cycles, expected beat 77 reached");
        end
        cycle(1'b1, 1'b0, 1'b1, 2'b00, 1'b1);
        repeat (20) cycle(1'b1, 1'b0, 1'b1, 2'b00, 1'b0);

        // Randomized play/pause, restart, loop and tempo changes.
        p = 1'b1; l = 1'b0; t = 2'b00;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(99) < 4)   p = ~p;
            if ($urandom_range(299) == 0) l = ~l;
            if ($urandom_range(59) == 0)  t = 2'($urandom_range(3));
            r = ($urandom_range(399) == 0);
            cycle(p, r, l, t, ($urandom_range(2999) == 0));
        end

        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
